// File: rtl/crc4fsk_pkg.sv
// Shared constants, TX state encoding and derived-size helper for the M-FSK frame serdes.
// Defaults describe the 16-bit CRC word carried as 4FSK at 256 samples per symbol.
package crc4fsk_pkg;

  localparam int SAMPLES_PER_SYM_DEF = 256;
  localparam int FRAME_BITS_DEF      = 16;
  localparam int BITS_PER_SYM_DEF    = 2;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_SEND = 2'd2
  } tx_state_e;

  function automatic int nsym(input int frame_bits, input int bits_per_sym);
    return frame_bits / bits_per_sym;
  endfunction

endpackage

// File: rtl/fsk_frame_serdes_if.sv
// Frame/symbol bundle between the serdes (slave) and the CRC framer and modem (master).
// TX side is ready/valid; RX side has no back-pressure.
interface fsk_frame_serdes_if
  import crc4fsk_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF
);

  logic [FRAME_BITS-1:0]   tx_frame;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [BITS_PER_SYM-1:0] tx_sym;
  logic                    tx_sym_valid;
  logic [BITS_PER_SYM-1:0] rx_sym;
  logic                    rx_sym_valid;
  logic [FRAME_BITS-1:0]   rx_frame;
  logic                    rx_frame_valid;
  logic                    rx_frame_err;

  modport master (
    output tx_frame, tx_valid, rx_sym, rx_sym_valid,
    input  tx_ready, tx_sym, tx_sym_valid, rx_frame, rx_frame_valid, rx_frame_err
  );

  modport slave (
    input  tx_frame, tx_valid, rx_sym, rx_sym_valid,
    output tx_ready, tx_sym, tx_sym_valid, rx_frame, rx_frame_valid, rx_frame_err
  );

endinterface

// File: rtl/fsk_sym_timer.sv
// Free-running phase/symbol-slot counters with symbol-wrap, frame-boundary and sample-edge flags.
// Flags are combinational from the counter registers; the counters never stall.
module fsk_sym_timer #(
  parameter int SAMPLES_PER_SYM = 256,
  parameter int NSYM            = 8,
  parameter int SAMPLE_PHASE    = 128,
  parameter int PW              = 8,
  parameter int SW              = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [PW-1:0] phase_o,
  output logic [SW-1:0] sym_idx_o,
  output logic          sym_strobe_o,
  output logic          sym_wrap_o,
  output logic          fbe_o,
  output logic          sample_o
);

  localparam logic [PW-1:0] PH_LAST   = PW'(SAMPLES_PER_SYM - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [SW-1:0] IDX_LAST  = SW'(NSYM - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] sym_idx_q, sym_idx_d;

  assign sym_wrap_o   = (phase_q == PH_LAST);
  assign fbe_o        = sym_wrap_o && (sym_idx_q == IDX_LAST);
  assign sample_o     = (phase_q == PH_SAMPLE);
  assign sym_strobe_o = (phase_q == '0) && !rst_i;
  assign phase_o      = phase_q;
  assign sym_idx_o    = sym_idx_q;

  always_comb begin
    phase_d   = sym_wrap_o ? '0 : phase_q + PW'(1);
    sym_idx_d = sym_idx_q;
    if (sym_wrap_o) begin
      sym_idx_d = (sym_idx_q == IDX_LAST) ? '0 : sym_idx_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= '0;
      sym_idx_q <= '0;
    end else begin
      phase_q   <= phase_d;
      sym_idx_q <= sym_idx_d;
    end
  end

endmodule

// File: rtl/fsk_frame_serdes.sv
// Frame <-> symbol serdes: TX frames start on frame boundaries (back-to-back allowed), RX frames
// are reassembled with an RX_LAG-symbol offset and delivered atomically one cycle after the last slot.
module fsk_frame_serdes
  import crc4fsk_pkg::*;
#(
  parameter int SAMPLES_PER_SYM = SAMPLES_PER_SYM_DEF,
  parameter int FRAME_BITS      = FRAME_BITS_DEF,
  parameter int BITS_PER_SYM    = BITS_PER_SYM_DEF,
  parameter int RX_LAG          = 2,
  parameter int SAMPLE_PHASE    = SAMPLES_PER_SYM / 2,
  localparam int NSYM           = nsym(FRAME_BITS, BITS_PER_SYM),
  localparam int PW             = $clog2(SAMPLES_PER_SYM),
  localparam int SW             = $clog2(NSYM)
) (
  input  logic             clk_sys,
  input  logic             rst,
  fsk_frame_serdes_if.slave bus,
  output logic [PW-1:0]    phase,
  output logic [SW-1:0]    sym_idx,
  output logic             sym_strobe
);

  localparam logic [SW-1:0] IDX_LAST = SW'(NSYM - 1);
  localparam logic [SW-1:0] LAG_W    = SW'(RX_LAG);

  logic sym_wrap, fbe, sample;

  fsk_sym_timer #(
    .SAMPLES_PER_SYM(SAMPLES_PER_SYM),
    .NSYM           (NSYM),
    .SAMPLE_PHASE   (SAMPLE_PHASE),
    .PW             (PW),
    .SW             (SW)
  ) u_timer (
    .clk_i       (clk_sys),
    .rst_i       (rst),
    .phase_o     (phase),
    .sym_idx_o   (sym_idx),
    .sym_strobe_o(sym_strobe),
    .sym_wrap_o  (sym_wrap),
    .fbe_o       (fbe),
    .sample_o    (sample)
  );

  tx_state_e               state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d, load_src;
  logic [BITS_PER_SYM-1:0] tx_sym_q, tx_sym_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    tx_ready, tx_hs;

  always_ff @(posedge clk_sys) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  // A mid-symbol accept during the last SEND symbol parks in WAIT so tx_ready drops until the FBE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (tx_hs) state_d = fbe ? TX_SEND : TX_WAIT;
      TX_WAIT: if (fbe) state_d = TX_SEND;
      TX_SEND: begin
        if (fbe)        state_d = tx_hs ? TX_SEND : TX_IDLE;
        else if (tx_hs) state_d = TX_WAIT;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == TX_IDLE) || ((state_q == TX_SEND) && (sym_idx == IDX_LAST));
    tx_hs    = bus.tx_valid && tx_ready;
    load_src = tx_hs ? bus.tx_frame : frame_q;
    frame_d  = frame_q;
    tx_sym_d = tx_sym_q;
    tx_vld_d = tx_vld_q;
    if (fbe && (tx_hs || (state_q == TX_WAIT))) begin
      tx_sym_d = load_src[BITS_PER_SYM-1:0];
      frame_d  = load_src >> BITS_PER_SYM;
      tx_vld_d = 1'b1;
    end else if (fbe && (state_q == TX_SEND)) begin
      tx_sym_d = '0;
      tx_vld_d = 1'b0;
    end else if (sym_wrap && (state_q == TX_SEND)) begin
      tx_sym_d = frame_q[BITS_PER_SYM-1:0];
      frame_d  = frame_q >> BITS_PER_SYM;
    end else if (tx_hs) begin
      frame_d = bus.tx_frame;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      frame_q  <= '0;
      tx_sym_q <= '0;
      tx_vld_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      tx_sym_q <= tx_sym_d;
      tx_vld_q <= tx_vld_d;
    end
  end

  assign bus.tx_ready     = tx_ready;
  assign bus.tx_sym       = tx_sym_q;
  assign bus.tx_sym_valid = tx_vld_q;

  logic [FRAME_BITS-1:0] shadow_q, shadow_d, rx_frame_q, rx_frame_d;
  logic [NSYM-1:0]       filled_q, filled_d;
  logic                  acc_q, acc_d, rx_vld_q, rx_vld_d, rx_err_q, rx_err_d;
  logic [SW-1:0]         slot;

  assign slot = (sym_idx >= LAG_W) ? sym_idx - LAG_W : sym_idx + SW'(NSYM - RX_LAG);

  // filled_q gates the first delivery until every slot has been written since reset.
  always_comb begin
    shadow_d   = shadow_q;
    filled_d   = filled_q;
    acc_d      = acc_q;
    rx_frame_d = rx_frame_q;
    rx_vld_d   = 1'b0;
    rx_err_d   = rx_err_q;
    if (sample) begin
      for (int k = 0; k < NSYM; k++) begin
        if (slot == SW'(k)) shadow_d[k*BITS_PER_SYM +: BITS_PER_SYM] = bus.rx_sym;
      end
      filled_d[slot] = 1'b1;
      acc_d          = acc_q | !bus.rx_sym_valid;
      if (slot == IDX_LAST) begin
        acc_d = 1'b0;
        if (&filled_d) begin
          rx_frame_d = shadow_d;
          rx_vld_d   = 1'b1;
          rx_err_d   = acc_q | !bus.rx_sym_valid;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shadow_q   <= '0;
      filled_q   <= '0;
      acc_q      <= 1'b0;
      rx_frame_q <= '0;
      rx_vld_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      filled_q   <= filled_d;
      acc_q      <= acc_d;
      rx_frame_q <= rx_frame_d;
      rx_vld_q   <= rx_vld_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign bus.rx_frame       = rx_frame_q;
  assign bus.rx_frame_valid = rx_vld_q;
  assign bus.rx_frame_err   = rx_err_q;

endmodule

// File: tb/tb_fsk_frame_serdes.sv
// Bench for fsk_frame_serdes: frame-schedule/sample-history model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_fsk_frame_serdes;

  localparam int SPS  = 4;
  localparam int FB   = 8;
  localparam int BPS  = 2;
  localparam int LAG  = 1;
  localparam int SPH  = 2;
  localparam int NS   = FB / BPS;
  localparam int FLEN = SPS * NS;

  logic clk_sys = 1'b0;
  logic rst;
  logic [1:0] phase, sym_idx;
  logic sym_strobe;

  always #5 clk_sys = ~clk_sys;

  fsk_frame_serdes_if #(.FRAME_BITS(FB), .BITS_PER_SYM(BPS)) bus ();

  fsk_frame_serdes #(
    .SAMPLES_PER_SYM(SPS), .FRAME_BITS(FB), .BITS_PER_SYM(BPS),
    .RX_LAG(LAG), .SAMPLE_PHASE(SPH)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .bus       (bus),
    .phase     (phase),
    .sym_idx   (sym_idx),
    .sym_strobe(sym_strobe)
  );

  typedef struct {
    int            start;
    logic [FB-1:0] f;
  } txf_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run = 0;
  bit   chk_en = 1'b0;
  txf_t sched[$];
  int   last_end;
  logic [BPS-1:0] rxs_h [0:4095];
  logic           rxv_h [0:4095];

  int             exp_phase, exp_idx;
  bit             exp_ready, exp_tx_vld, exp_rx_vld, exp_rx_err;
  logic [BPS-1:0] exp_tx_sym;
  logic [FB-1:0]  exp_rx_frame;

  logic [1:0] b4_tab [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0] e1_tab [4] = '{2'd2, 2'd3, 2'd1, 2'd0};

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s run=%0d cyc=%0d actual=%0h expected=%0h", nm, run, cyc, act, exp_v);
    end
  endtask

  // Symbol on the TX line at cycle n according to the accepted-frame schedule.
  function automatic void tx_at(input int n, output logic [BPS-1:0] s, output bit v);
    s = '0;
    v = 1'b0;
    foreach (sched[i]) begin
      if (n >= sched[i].start && n < sched[i].start + FLEN) begin
        v = 1'b1;
        s = BPS'(sched[i].f >> (((n - sched[i].start) / SPS) * BPS));
      end
    end
  endfunction

  task automatic model_reset();
    cyc = 0;
    sched.delete();
    last_end = 0;
    exp_rx_frame = '0;
    exp_rx_err = 1'b0;
    exp_rx_vld = 1'b0;
  endtask

  task automatic model_step();
    int m, idx;
    logic [FB-1:0] fr;
    bit er;
    exp_phase = cyc % SPS;
    exp_idx   = (cyc / SPS) % NS;
    exp_ready = (cyc >= last_end - SPS);
    tx_at(cyc, exp_tx_sym, exp_tx_vld);
    exp_rx_vld = 1'b0;
    m = cyc - 1;
    // m is the sample of the last slot; all NS samples of the frame must postdate reset.
    if (m - (NS - 1) * SPS >= 0 && m % SPS == SPH && (m / SPS) % NS == (NS - 1 + LAG) % NS) begin
      fr = '0;
      er = 1'b0;
      for (int k = 0; k < NS; k++) begin
        idx = m - (NS - 1 - k) * SPS;
        fr[k*BPS +: BPS] = rxs_h[idx];
        er = er | !rxv_h[idx];
      end
      exp_rx_frame = fr;
      exp_rx_err   = er;
      exp_rx_vld   = 1'b1;
    end
  endtask

  task automatic drive();
    logic [FB-1:0]  f;
    bit             v;
    logic [BPS-1:0] s;
    bit             sv;
    txf_t           e;
    f = 8'hFF;
    v = 1'b0;
    if (run == 0) begin
      case (cyc)
        5:       begin v = 1'b1; f = 8'hB4; end
        29, 30:  begin v = 1'b1; f = 8'h1E; end
        47:      begin v = 1'b1; f = 8'h27; end
        79:      begin v = 1'b1; f = 8'hC9; end
        100:     begin v = 1'b1; f = 8'h5A; end
        default: ;
      endcase
    end
    bus.tx_valid = v;
    bus.tx_frame = f;
    if (v && exp_ready) begin
      e.start = (cyc / FLEN + 1) * FLEN;
      e.f     = f;
      sched.push_back(e);
      last_end = e.start + FLEN;
    end
    if (run == 0) begin
      tx_at(cyc - SPS, s, sv);
      bus.rx_sym       = s;
      bus.rx_sym_valid = !(cyc >= 41 && cyc <= 43);
    end else begin
      bus.rx_sym       = BPS'(cyc / SPS);
      bus.rx_sym_valid = 1'b1;
    end
    rxs_h[cyc] = bus.rx_sym;
    rxv_h[cyc] = bus.rx_sym_valid;
    if (run == 0 && cyc == 121) rst = 1'b1;
  endtask

  task automatic lit();
    if (run == 0) begin
      if (cyc == 0) begin
        chk("rst_phase", phase, 0);
        chk("rst_sym_idx", sym_idx, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_tx_sym_valid", bus.tx_sym_valid, 0);
        chk("rst_rx_frame", bus.rx_frame, 0);
      end
      if (cyc == 4) chk("strobe_on", sym_strobe, 1);
      if (cyc == 5) chk("strobe_off", sym_strobe, 0);
      if (cyc == 3) chk("early_rx_suppressed", bus.rx_frame_valid, 0);
      if (cyc == 15) chk("b4_not_yet", bus.tx_sym_valid, 0);
      if (cyc >= 16 && cyc < 32 && cyc % 4 == 0) begin
        chk("b4_sym", bus.tx_sym, b4_tab[(cyc - 16) / 4]);
        chk("b4_vld", bus.tx_sym_valid, 1);
      end
      if (cyc == 30) chk("ready_drop_after_hs", bus.tx_ready, 0);
      if (cyc >= 32 && cyc < 48 && cyc % 4 == 0) begin
        chk("1e_sym", bus.tx_sym, e1_tab[(cyc - 32) / 4]);
        chk("1e_vld", bus.tx_sym_valid, 1);
      end
      if (cyc == 64) chk("idle_after_27", bus.tx_sym_valid, 0);
      if (cyc == 35) begin
        chk("rx_b4_vld", bus.rx_frame_valid, 1);
        chk("rx_b4_frame", bus.rx_frame, 8'hB4);
        chk("rx_b4_err", bus.rx_frame_err, 0);
      end
      if (cyc == 51) begin
        chk("rx_1e_vld", bus.rx_frame_valid, 1);
        chk("rx_1e_frame", bus.rx_frame, 8'h1E);
        chk("rx_1e_err", bus.rx_frame_err, 1);
      end
      if (cyc == 67) begin
        chk("rx_27_frame", bus.rx_frame, 8'h27);
        chk("rx_27_err", bus.rx_frame_err, 0);
      end
    end else begin
      if (cyc == 0) begin
        chk("midrst_tx_sym", bus.tx_sym, 0);
        chk("midrst_tx_sym_valid", bus.tx_sym_valid, 0);
        chk("midrst_tx_ready", bus.tx_ready, 1);
        chk("midrst_phase", phase, 0);
      end
      if (cyc == 3) chk("midrst_early_rx", bus.rx_frame_valid, 0);
      if (cyc == 19) begin
        chk("midrst_rx_vld", bus.rx_frame_valid, 1);
        chk("midrst_rx_frame", bus.rx_frame, 8'h39);
      end
    end
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("phase", phase, exp_phase);
      chk("sym_idx", sym_idx, exp_idx);
      chk("sym_strobe", sym_strobe, int'(exp_phase == 0 && !rst));
      chk("tx_ready", bus.tx_ready, exp_ready);
      chk("tx_sym_valid", bus.tx_sym_valid, exp_tx_vld);
      chk("tx_sym", bus.tx_sym, exp_tx_sym);
      chk("rx_frame_valid", bus.rx_frame_valid, exp_rx_vld);
      chk("rx_frame", bus.rx_frame, exp_rx_frame);
      if (exp_rx_vld) chk("rx_frame_err", bus.rx_frame_err, exp_rx_err);
    end
  end

  initial begin
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_frame = '0;
    bus.rx_sym = '0;
    bus.rx_sym_valid = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    model_reset();
    model_step();
    drive();
    chk_en = 1'b1;
    #1 lit();
    for (int k = 0; k < 400 && !(run == 1 && cyc >= 40); k++) begin
      @(posedge clk_sys);
      #1;
      if (rst) begin
        rst = 1'b0;
        run = 1;
        model_reset();
      end else begin
        cyc++;
      end
      model_step();
      drive();
      #1 lit();
    end
    if (!(run == 1 && cyc >= 40)) begin
      errors++;
      $display("FAIL scenario_budget run=%0d cyc=%0d", run, cyc);
    end
    @(negedge clk_sys);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
